// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: holds the PC, fetches over a req/rsp handshake, and hands Instr/PC to decode.
// Optional FETCH_MISALIGN_CHECK_EN: a misaligned next PC halts fetch and raises a sticky fetch_fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] PCTarget,
  input  logic [31:0] ALUResult,
  input  logic        exec_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        instr_valid,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_e;

  state_e      state_q;
  logic [31:0] pc_fetch_q, pc_q, instr_q;
  logic        req_q, valid_q;
  logic [31:0] next_sel, next_pc_d;

  always_comb begin
    next_sel = pc_q + 32'd4;
    case (PCSrc)
      2'b01:   next_sel = PCTarget;
      2'b10:   next_sel = ALUResult;
      default: next_sel = pc_q + 32'd4;
    endcase
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign;
  logic fault_q;
  assign misalign    = |next_sel[1:0];
  assign next_pc_d   = next_sel;
  assign fetch_fault = fault_q;
`else
  assign next_pc_d   = next_sel & ~32'h0000_0003;
  assign fetch_fault = 1'b0;
`endif

  // req_q is only raised on the cycle after reset release, so a ready seen
  // while req_q is still low is not an accept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_REQ;
      pc_fetch_q <= RESET_PC;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_REQ: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (imem_ready) begin
            req_q   <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instr_q <= imem_rdata;
            pc_q    <= pc_fetch_q;
            valid_q <= 1'b1;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (exec_ready) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (misalign) begin
              fault_q <= 1'b1;
              state_q <= S_HALT;
            end else begin
              pc_fetch_q <= next_pc_d;
              req_q      <= 1'b1;
              state_q    <= S_REQ;
            end
`else
            pc_fetch_q <= next_pc_d;
            req_q      <= 1'b1;
            state_q    <= S_REQ;
`endif
          end
        end
        S_HALT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_fetch_q;
  assign Instr       = instr_q;
  assign PC          = pc_q;
  assign PCPlus4     = pc_q + 32'd4;
  assign instr_valid = valid_q;

endmodule
